// File: rtl/scramble_pkg.sv
// Shared state encoding and LFSR constants for the scramble/solve controller.
// Optional build macro SCRAMBLE_NO_REPEAT_EN is consumed by scramble_solve_ctrl.
package scramble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCRAMBLE = 2'd1,
        ST_SOLVE    = 2'd2,
        ST_SOLVED   = 2'd3
    } state_e;

    // Right-shifting Galois masks giving maximal-length sequences.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            32'd8:   taps = {24'd0, LFSR_TAPS_8};
            32'd16:  taps = {16'd0, LFSR_TAPS_16};
            32'd32:  taps = LFSR_TAPS_32;
            default: taps = 32'd0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/scramble_lfsr.sv
// Free-running Galois LFSR, loaded with SEED while rst is high.
// Only the low OUT_W bits are exported as the move candidate.
module scramble_lfsr #(
    parameter int unsigned    W     = 16,
    parameter int unsigned    OUT_W = 4,
    parameter logic [W-1:0]   SEED  = W'(16'hACE1),
    parameter logic [W-1:0]   TAPS  = W'(16'hB400)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // One Galois step: shift right, fold the mask in when a one falls out.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : {W{1'b0}});
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/scramble_solve_ctrl.sv
// Puzzle phase sequencer: streams NUM_MOVES pseudo-random moves, then gates the buzzer.
// Define SCRAMBLE_NO_REPEAT_EN to forbid two identical consecutive moves.
module scramble_solve_ctrl
    import scramble_pkg::*;
#(
    parameter int unsigned       NUM_MOVES   = 31,
    parameter int unsigned       MOVE_W      = 4,
    parameter int unsigned       LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'(DEFAULT_SEED),
    parameter int unsigned       BUZZ_CYCLES = 8,
    localparam int unsigned      ML_W        = $clog2(NUM_MOVES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scramble_btn,
    input  logic              solved_in,
    input  logic              move_ready,
    output logic              move_valid,
    output logic [MOVE_W-1:0] move_code,
    output logic              no_buzz,
    output logic              buzz_pulse,
    output logic              busy,
    output logic [1:0]        state_out,
    output logic [ML_W-1:0]   moves_left
);

    localparam int unsigned       BC_W = $clog2(BUZZ_CYCLES + 1);
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    state_e            state_q, state_d;
    logic [ML_W-1:0]   ml_q, ml_d;
    logic [MOVE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic [BC_W-1:0]   buzz_cnt_q, buzz_cnt_d;
    logic              no_buzz_q, buzz_pulse_q, busy_q;
    logic              btn_meta_q, btn_sync_q, btn_prev_q;
    logic              btn_rise_s;
    logic [MOVE_W-1:0] cand_s;
    logic              ok_cur_s, ok_last_s;

    scramble_lfsr #(
        .W     (LFSR_W),
        .OUT_W (MOVE_W),
        .SEED  (LFSR_SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (cand_s)
    );

    // Button synchroniser plus previous-sample flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= scramble_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign btn_rise_s = btn_sync_q & ~btn_prev_q;

`ifdef SCRAMBLE_NO_REPEAT_EN
    logic [MOVE_W-1:0] last_q, last_d;
    // ok_cur_s guards against the move being transferred now, ok_last_s against the last one sent.
    assign ok_cur_s  = (cand_s != code_q);
    assign ok_last_s = (cand_s != last_q);
`else
    assign ok_cur_s  = 1'b1;
    assign ok_last_s = 1'b1;
`endif

    // Next-state and datapath decisions.
    always_comb begin
        state_d    = state_q;
        ml_d       = ml_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        buzz_cnt_d = buzz_cnt_q;
`ifdef SCRAMBLE_NO_REPEAT_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE, ST_SOLVE: begin
                if ((state_q == ST_SOLVE) && solved_in) begin
                    state_d    = ST_SOLVED;
                    buzz_cnt_d = BC_W'(BUZZ_CYCLES);
                end else if (btn_rise_s) begin
                    state_d = ST_SCRAMBLE;
                    ml_d    = ML_W'(NUM_MOVES);
                    if (ok_last_s) begin
                        code_d  = cand_s;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_SCRAMBLE: begin
                if (valid_q && move_ready) begin
                    ml_d = ml_q - ML_W'(1);
`ifdef SCRAMBLE_NO_REPEAT_EN
                    last_d = code_q;
`endif
                    if (ml_q == ML_W'(1)) begin
                        state_d = ST_SOLVE;
                        valid_d = 1'b0;
                    end else if (ok_cur_s) begin
                        code_d  = cand_s;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (valid_q) begin
                    valid_d = 1'b1;
                end else if (ok_last_s) begin
                    // A rejected repeat left the slot empty; retry with the fresh candidate.
                    code_d  = cand_s;
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_SOLVED: begin
                if (buzz_cnt_q <= BC_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    buzz_cnt_d = buzz_cnt_q - BC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; phase flags are precomputed from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ml_q         <= {ML_W{1'b0}};
            code_q       <= {MOVE_W{1'b0}};
            valid_q      <= 1'b0;
            buzz_cnt_q   <= {BC_W{1'b0}};
            no_buzz_q    <= 1'b1;
            buzz_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SCRAMBLE_NO_REPEAT_EN
            last_q       <= {MOVE_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            ml_q         <= ml_d;
            code_q       <= code_d;
            valid_q      <= valid_d;
            buzz_cnt_q   <= buzz_cnt_d;
            no_buzz_q    <= (state_d != ST_SOLVE);
            buzz_pulse_q <= (state_d == ST_SOLVED);
            busy_q       <= (state_d == ST_SCRAMBLE);
`ifdef SCRAMBLE_NO_REPEAT_EN
            last_q       <= last_d;
`endif
        end
    end

    assign move_valid = valid_q;
    assign move_code  = code_q;
    assign no_buzz    = no_buzz_q;
    assign buzz_pulse = buzz_pulse_q;
    assign busy       = busy_q;
    assign state_out  = state_q;
    assign moves_left = ml_q;

endmodule

// File: tb/tb_scramble_solve_ctrl.sv
// Self-checking bench for scramble_solve_ctrl: table-driven phase walk plus a move scoreboard.
module tb_scramble_solve_ctrl;

    localparam int          NM   = 31;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       rst;
    logic       scramble_btn;
    logic       solved_in;
    logic       move_ready;
    logic       move_valid;
    logic [3:0] move_code;
    logic       no_buzz;
    logic       buzz_pulse;
    logic       busy;
    logic [1:0] state_out;
    logic [4:0] moves_left;

    scramble_solve_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .scramble_btn (scramble_btn),
        .solved_in    (solved_in),
        .move_ready   (move_ready),
        .move_valid   (move_valid),
        .move_code    (move_code),
        .no_buzz      (no_buzz),
        .buzz_pulse   (buzz_pulse),
        .busy         (busy),
        .state_out    (state_out),
        .moves_left   (moves_left)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    int          cyc         = 0;
    int          rise_cyc    = -100;
    bit          rise_expect = 1'b0;
    int          xfers       = 0;
    int          m_left      = 0;
    logic [15:0] m_lfsr      = SEED;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;
    logic [3:0]  hold_code   = 4'd0;
    logic [3:0]  last_xfer   = 4'd0;
    bit          hold_chk    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr    = SEED;
            m_left    = 0;
            hold_chk  = 1'b0;
            last_xfer = 4'd0;
            exp_q.delete();
        end else begin
            if (hold_chk) begin
                chk("hold_valid", {31'd0, move_valid}, 32'd1);
                chk("hold_code", {28'd0, move_code}, {28'd0, hold_code});
            end
            hold_chk  = move_valid && !move_ready;
            hold_code = move_code;
            if (move_valid && move_ready) begin
                xfers++;
                chk("xfer_moves_left", {27'd0, moves_left}, m_left);
`ifdef SCRAMBLE_NO_REPEAT_EN
                chk("no_repeat", {31'd0, move_code == last_xfer}, 32'd0);
`else
                chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_code = exp_q.pop_front();
                    chk("move_code", {28'd0, move_code}, {28'd0, exp_code});
                end
`endif
                last_xfer = move_code;
                if (m_left > 0) m_left--;
                if (m_left > 0) exp_q.push_back(m_lfsr[3:0]);
            end
            if (cyc == rise_cyc && rise_expect) begin
                m_left = NM;
                exp_q.push_back(m_lfsr[3:0]);
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
        cyc++;
    end

    // ---------------- helpers ----------------
    task automatic press(input bit start);
        @(negedge clk);
        scramble_btn = 1'b1;
        rise_expect  = start;
        rise_cyc     = cyc + 2;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int k = 0;
        while (state_out !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {30'd0, state_out}, {30'd0, s});
    endtask

    typedef struct {
        logic       solved;
        logic [1:0] st;
        logic       nb;
        logic       bz;
        logic       bs;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int vcount;
        int gaps;
        int x0;
        int k;
        bit seen;
        bit prev_v;

        // SOLVE -> SOLVED (8 buzz cycles) -> IDLE, one record per clock.
        tbl[0] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
        for (int i = 1; i < 8; i++) tbl[i] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; scramble_btn = 1'b0; solved_in = 1'b0; move_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {30'd0, state_out}, 32'd0);
        chk("rst_valid", {31'd0, move_valid}, 32'd0);
        chk("rst_code", {28'd0, move_code}, 32'd0);
        chk("rst_no_buzz", {31'd0, no_buzz}, 32'd1);
        chk("rst_buzz", {31'd0, buzz_pulse}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_moves_left", {27'd0, moves_left}, 32'd0);
        rst = 1'b0;

        repeat (20) @(negedge clk);
        chk("idle_state", {30'd0, state_out}, 32'd0);
        chk("idle_no_buzz", {31'd0, no_buzz}, 32'd1);
        chk("idle_valid", {31'd0, move_valid}, 32'd0);
        chk("idle_buzz", {31'd0, buzz_pulse}, 32'd0);

        // Full scramble with ready tied high.
        move_ready = 1'b1;
        press(1'b1);
        vcount = 0; gaps = 0; seen = 1'b0; prev_v = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 3) scramble_btn = 1'b0;
            if (i == 1) chk("btn_latency_early", {30'd0, state_out}, 32'd0);
            if (i == 2) chk("btn_latency", {30'd0, state_out}, 32'd1);
            if (move_valid) begin
                chk("run_moves_left", {27'd0, moves_left}, NM - vcount);
                if (seen && !prev_v) gaps++;
                vcount++;
                seen = 1'b1;
            end
            prev_v = move_valid;
        end
        chk("run_length", vcount, NM);
`ifndef SCRAMBLE_NO_REPEAT_EN
        chk("run_gaps", gaps, 0);
`endif
        chk("solve_state", {30'd0, state_out}, 32'd2);
        chk("solve_no_buzz", {31'd0, no_buzz}, 32'd0);
        chk("solve_busy", {31'd0, busy}, 32'd0);
        chk("solve_moves_left", {27'd0, moves_left}, 32'd0);

        // Table-driven walk through SOLVED and back to IDLE.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            solved_in = tbl[i].solved;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_state", i), {30'd0, state_out}, {30'd0, tbl[i].st});
            chk($sformatf("tbl%0d_no_buzz", i), {31'd0, no_buzz}, {31'd0, tbl[i].nb});
            chk($sformatf("tbl%0d_buzz", i), {31'd0, buzz_pulse}, {31'd0, tbl[i].bz});
            chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bs});
        end
        @(negedge clk);
        solved_in = 1'b0;

        // Scramble with random back-pressure (~30% ready).
        x0 = xfers;
        press(1'b1);
        k = 0;
        do begin
            @(negedge clk);
            move_ready = ($urandom_range(0, 9) < 3);
            if (k == 4) scramble_btn = 1'b0;
            k++;
        end while (state_out != 2'd2 && k < 2000);
        scramble_btn = 1'b0;
        chk("rand_reached_solve", {30'd0, state_out}, 32'd2);
        chk("rand_xfers", xfers - x0, NM);
`ifndef SCRAMBLE_NO_REPEAT_EN
        chk("sb_drained", exp_q.size(), 0);
`endif

        // Re-scramble from SOLVE; a press mid-scramble must not reload.
        move_ready = 1'b0;
        press(1'b1);
        repeat (4) @(negedge clk);
        scramble_btn = 1'b0;
        chk("resc_state", {30'd0, state_out}, 32'd1);
        chk("resc_moves_left", {27'd0, moves_left}, NM);
        press(1'b0);
        repeat (6) @(negedge clk);
        scramble_btn = 1'b0;
        chk("midpress_state", {30'd0, state_out}, 32'd1);
        chk("midpress_moves_left", {27'd0, moves_left}, NM);
        move_ready = 1'b1;
        wait_state(2'd2, 100, "resc_done");

        // solved_in and button rise on the same edge: solved wins.
        press(1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        solved_in = 1'b1;
        @(negedge clk);
        solved_in = 1'b0;
        chk("solved_wins", {30'd0, state_out}, 32'd3);
        repeat (3) @(negedge clk);
        scramble_btn = 1'b0;
        wait_state(2'd0, 30, "buzz_done");
        chk("buzz_done_no_buzz", {31'd0, no_buzz}, 32'd1);

        // Reset in the middle of a scramble.
        press(1'b1);
        k = 0;
        while (!(moves_left == 5'd10 && move_valid) && k < 100) begin
            @(negedge clk);
            if (k == 4) scramble_btn = 1'b0;
            k++;
        end
        scramble_btn = 1'b0;
        move_ready   = 1'b0;
        chk("pre_rst_valid", {31'd0, move_valid}, 32'd1);
        chk("pre_rst_moves_left", {27'd0, moves_left}, 32'd10);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, move_valid}, 32'd0);
        chk("midrst_state", {30'd0, state_out}, 32'd0);
        chk("midrst_moves_left", {27'd0, moves_left}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_state", {30'd0, state_out}, 32'd0);

`ifdef SCRAMBLE_NO_REPEAT_EN
        move_ready = 1'b1;
        for (int s = 0; s < 1000; s++) begin
            press(1'b1);
            repeat (4) @(negedge clk);
            scramble_btn = 1'b0;
            wait_state(2'd2, 200, "nr_solve");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
